fma_data_cache: RTL and testbench
=================================

# fma_data_cache

- Parametrised data cache controller for the FPGA-GPU memory unit.
- Decodes memory instructions (SMA, LOADI, LOADB, WRITEB) and owns an internal single-port, read-first BRAM of DEPTH lines.
- Each line holds the a/b/c operands for FMA_COUNT FMAs.
- Ready/valid handshakes on the instruction, buffer and FMA-output sides; optional address auto-increment for streaming lines.

## Interface
Parameters:
- FMA_COUNT, 2, FMAs fed per line; WORDS = 3*FMA_COUNT (max 16)
- WORD_WIDTH, 16, bits per word; LINE_WIDTH = WORDS*WORD_WIDTH
- DEPTH, 375, lines in cache; ADDR_WIDTH = $clog2(DEPTH)
- INSTRUCTION_WIDTH, 32, instruction bits
- READ_LATENCY, 2, BRAM read latency in cycles (1 or 2)

Ports:
- clk_in  in  1  single clock, all logic on rising edge
- rst_in  in  1  asynchronous, active-high reset
- instr_in  in  INSTRUCTION_WIDTH  [31:28] opcode, [27:24] reg field, [23:8] immediate, [7:0] ignored
- instr_valid_in  in  1  instruction offered
- instr_ready_out  out  1  high in IDLE; transfer when valid && ready
- buffer_data_in  in  LINE_WIDTH  line from FMA buffer
- buffer_valid_in  in  1  buffer line offered
- buffer_ready_out  out  1  high only in WAIT_BUF
- abc_out  out  LINE_WIDTH  line to FMAs; word k at bits [LINE_WIDTH-1-k*WORD_WIDTH -: WORD_WIDTH]
- abc_valid_out  out  1  abc_out valid, held until accepted
- abc_ready_in  in  1  FMA side accepts abc_out
- idle_out  out  1  state IDLE and staging mask empty
- error_out  out  1  sticky error flag
- error_code_out  out  2  first error: 01 bad word index, 10 address >= DEPTH

## Operation
- States: IDLE, WR_LINE, WAIT_BUF, RD_WAIT, RD_OUT.
- Registers:
  - addr (ADDR_WIDTH)
  - staging line (LINE_WIDTH)
  - valid mask (WORDS bits)
  - latency counter
- Opcodes, accepted in IDLE only:
  - 0110 SMA: if imm < DEPTH, addr <= imm[ADDR_WIDTH-1:0]; else error 10, addr unchanged. Stay IDLE.
  - 0111 LOADI: if reg < WORDS, staging word[reg] <= imm and mask[reg] <= 1; else error 01, no effect. If the mask becomes all-ones including this word, go to WR_LINE. Otherwise stay IDLE.
  - 1000 LOADB: go to WAIT_BUF.
  - 1001 WRITEB: issue BRAM read at addr in the accept cycle; go to RD_WAIT.
  - All other opcodes (NOP, ALU, branch) are consumed with no effect.
- WR_LINE: write staging line to BRAM[addr], clear mask, return to IDLE. Writing an already-valid word overwrites it and does not change the mask.
- WAIT_BUF: on buffer_valid_in, write buffer_data_in to BRAM[addr], go to IDLE. Waits indefinitely otherwise.
- RD_WAIT: count READ_LATENCY cycles, latch BRAM output into abc_out, go to RD_OUT.
- RD_OUT: hold abc_valid_out and abc_out stable until abc_ready_in, then IDLE.
- Address after a completed WR_LINE, LOADB or WRITEB: see Configuration. Wrap DEPTH-1 -> 0.
- Errors: error_out and error_code_out latch on the first error; later errors are ignored. Cleared only by reset.
- Reset, including mid-operation: returns to IDLE and clears the staging line, mask, counter and in-flight transfer. BRAM contents are preserved.
- Reset values of outputs:
  - instr_ready_out 1, idle_out 1
  - buffer_ready_out 0
  - abc_out 0, abc_valid_out 0
  - error_out 0, error_code_out 0

## Timing
- SMA, NOP, and non-completing LOADI: 1 cycle each; back-to-back acceptance every cycle.
- Completing LOADI: instr_ready_out low for 1 cycle (WR_LINE); BRAM written on that edge.
- LOADB: buffer_ready_out high from the cycle after accept. Write and return to IDLE on the edge where buffer_valid_in && buffer_ready_out.
- WRITEB:
  - abc_valid_out rises READ_LATENCY+1 cycles after the accept edge.
  - Same-cycle abc_ready_in returns to IDLE on the next edge.
  - Minimum WRITEB-to-next-instruction gap is READ_LATENCY+2 cycles.
- Read-first: a WRITEB immediately following a write to the same addr returns the new data, because the write completes before the read is issued.
- Simultaneous abc_ready_in while not in RD_OUT, or buffer_valid_in while not in WAIT_BUF: ignored.

## Configuration
- DATA_CACHE_AUTOINC_EN defined: addr increments by 1 after each completed WR_LINE, LOADB write, and WRITEB handshake, wrapping DEPTH-1 -> 0.
- Not defined: addr changes only on SMA.

## Test plan
Defaults unless noted: FMA_COUNT=2, WORD_WIDTH=16, DEPTH=375, READ_LATENCY=2.
- SMA 5; LOADI words 0..5 = 0x1111..0x6666; SMA 5; WRITEB -> abc_out = 0x111122223333444455556666, valid 3 cycles after accept, instr_ready_out low exactly 1 cycle after 6th LOADI.
- SMA 10; LOADB with buffer_valid_in delayed 4 cycles carrying 0xA5 pattern -> no write until handshake; SMA 10; WRITEB returns the pattern; abc_valid_out held 5 cycles while abc_ready_in low, data stable.
- DATA_CACHE_AUTOINC_EN: SMA 374; LOADB lineX; LOADB lineY -> lineX at 374, lineY at 0; without macro, lineY overwrites 374.
- LOADI reg=7 then SMA 400 -> error_out=1, error_code_out=01 (first error kept), addr and mask unchanged, idle_out=1.
- Assert rst_in during RD_WAIT and after 3 LOADIs -> all outputs at reset values immediately; mask empty; earlier BRAM line still readable via WRITEB.

Source files
------------

// File: rtl/fma_data_cache.sv
// fma_data_cache: memory-instruction decoder and line cache feeding the FMA array.
// Defining DATA_CACHE_AUTOINC_EN makes addr step after each completed line transfer.
module fma_data_cache #(
    parameter int FMA_COUNT         = 2,
    parameter int WORD_WIDTH        = 16,
    parameter int DEPTH             = 375,
    parameter int INSTRUCTION_WIDTH = 32,
    parameter int READ_LATENCY      = 2,
    localparam int WORDS      = 3 * FMA_COUNT,
    localparam int LINE_WIDTH = WORDS * WORD_WIDTH,
    localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic [INSTRUCTION_WIDTH-1:0] instr_in,
    input  logic                         instr_valid_in,
    output logic                         instr_ready_out,
    input  logic [LINE_WIDTH-1:0]        buffer_data_in,
    input  logic                         buffer_valid_in,
    output logic                         buffer_ready_out,
    output logic [LINE_WIDTH-1:0]        abc_out,
    output logic                         abc_valid_out,
    input  logic                         abc_ready_in,
    output logic                         idle_out,
    output logic                         error_out,
    output logic [1:0]                   error_code_out
);

    localparam logic [3:0] OP_SMA    = 4'b0110;
    localparam logic [3:0] OP_LOADI  = 4'b0111;
    localparam logic [3:0] OP_LOADB  = 4'b1000;
    localparam logic [3:0] OP_WRITEB = 4'b1001;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_LINE,
        S_WAIT_BUF,
        S_RD_WAIT,
        S_RD_OUT
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d, addr_step;
    logic [LINE_WIDTH-1:0] stage_q, stage_d;
    logic [WORDS-1:0]      mask_q, mask_d;
    logic [1:0]            cnt_q, cnt_d;
    logic [LINE_WIDTH-1:0] abc_q, abc_d;
    logic                  err_q, err_d;
    logic [1:0]            code_q, code_d;

    logic                  bram_we, bram_re;
    logic [LINE_WIDTH-1:0] bram_wdata, bram_out;
    logic [LINE_WIDTH-1:0] bram_rd1_q, bram_rd2_q;
    logic [LINE_WIDTH-1:0] mem [DEPTH];

    logic [3:0]            opcode, reg_f;
    logic [15:0]           imm;
    logic [WORD_WIDTH-1:0] imm_w;
    logic                  unused_bits;

    assign opcode      = instr_in[31:28];
    assign reg_f       = instr_in[27:24];
    assign imm         = instr_in[23:8];
    assign imm_w       = WORD_WIDTH'(imm);
    assign unused_bits = ^instr_in[7:0];

    assign bram_out = (READ_LATENCY == 1) ? bram_rd1_q : bram_rd2_q;

`ifdef DATA_CACHE_AUTOINC_EN
    assign addr_step = (addr_q == ADDR_WIDTH'(DEPTH - 1)) ? '0
                                                          : addr_q + ADDR_WIDTH'(1);
`else
    assign addr_step = addr_q;
`endif

    // Next-state, datapath updates and BRAM port control
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        stage_d    = stage_q;
        mask_d     = mask_q;
        cnt_d      = cnt_q;
        abc_d      = abc_q;
        err_d      = err_q;
        code_d     = code_q;
        bram_we    = 1'b0;
        bram_re    = 1'b0;
        bram_wdata = stage_q;
        unique case (state_q)
            S_IDLE: begin
                if (instr_valid_in) begin
                    case (opcode)
                        OP_SMA: begin
                            if (32'(imm) < DEPTH) begin
                                addr_d = ADDR_WIDTH'(imm);
                            end else if (!err_q) begin
                                err_d  = 1'b1;
                                code_d = 2'b10;
                            end
                        end
                        OP_LOADI: begin
                            if (32'(reg_f) < WORDS) begin
                                for (int k = 0; k < WORDS; k++) begin
                                    if (reg_f == 4'(k)) begin
                                        stage_d[LINE_WIDTH-1-k*WORD_WIDTH -: WORD_WIDTH] = imm_w;
                                        mask_d[k] = 1'b1;
                                    end
                                end
                                if (&mask_d) begin
                                    state_d = S_WR_LINE;
                                end
                            end else if (!err_q) begin
                                err_d  = 1'b1;
                                code_d = 2'b01;
                            end
                        end
                        OP_LOADB: state_d = S_WAIT_BUF;
                        OP_WRITEB: begin
                            bram_re = 1'b1;
                            cnt_d   = '0;
                            state_d = S_RD_WAIT;
                        end
                        default: ;
                    endcase
                end
            end
            S_WR_LINE: begin
                bram_we = 1'b1;
                mask_d  = '0;
                addr_d  = addr_step;
                state_d = S_IDLE;
            end
            S_WAIT_BUF: begin
                if (buffer_valid_in) begin
                    bram_we    = 1'b1;
                    bram_wdata = buffer_data_in;
                    addr_d     = addr_step;
                    state_d    = S_IDLE;
                end
            end
            S_RD_WAIT: begin
                if (cnt_q == 2'(READ_LATENCY)) begin
                    abc_d   = bram_out;
                    cnt_d   = '0;
                    state_d = S_RD_OUT;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            S_RD_OUT: begin
                if (abc_ready_in) begin
                    addr_d  = addr_step;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control and datapath registers; reset abandons any transfer in flight
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            stage_q <= '0;
            mask_q  <= '0;
            cnt_q   <= '0;
            abc_q   <= '0;
            err_q   <= 1'b0;
            code_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            stage_q <= stage_d;
            mask_q  <= mask_d;
            cnt_q   <= cnt_d;
            abc_q   <= abc_d;
            err_q   <= err_d;
            code_q  <= code_d;
        end
    end

    // Read-first BRAM with output pipeline; contents survive reset
    always_ff @(posedge clk_in) begin
        if (bram_we) begin
            mem[addr_q] <= bram_wdata;
        end
        if (bram_re) begin
            bram_rd1_q <= mem[addr_q];
        end
        bram_rd2_q <= bram_rd1_q;
    end

    assign instr_ready_out  = (state_q == S_IDLE);
    assign buffer_ready_out = (state_q == S_WAIT_BUF);
    assign abc_valid_out    = (state_q == S_RD_OUT);
    assign abc_out          = abc_q;
    assign idle_out         = (state_q == S_IDLE) && (mask_q == '0);
    assign error_out        = err_q;
    assign error_code_out   = code_q;

endmodule

// File: tb/tb_fma_data_cache.sv
// tb_fma_data_cache: directed and random instruction streams for fma_data_cache,
// checked against a line-level model of the cache (addr, staging words, memory).
module tb_fma_data_cache;

    localparam int W  = 6;
    localparam int LW = 96;
    localparam int D  = 375;
    localparam int RL = 2;

    logic          clk_in = 1'b0;
    logic          rst_in;
    logic [31:0]   instr_in;
    logic          instr_valid_in;
    logic          instr_ready_out;
    logic [LW-1:0] buffer_data_in;
    logic          buffer_valid_in;
    logic          buffer_ready_out;
    logic [LW-1:0] abc_out;
    logic          abc_valid_out;
    logic          abc_ready_in;
    logic          idle_out;
    logic          error_out;
    logic [1:0]    error_code_out;

    fma_data_cache #(
        .FMA_COUNT(2),
        .WORD_WIDTH(16),
        .DEPTH(D),
        .INSTRUCTION_WIDTH(32),
        .READ_LATENCY(RL)
    ) dut (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .instr_in(instr_in),
        .instr_valid_in(instr_valid_in),
        .instr_ready_out(instr_ready_out),
        .buffer_data_in(buffer_data_in),
        .buffer_valid_in(buffer_valid_in),
        .buffer_ready_out(buffer_ready_out),
        .abc_out(abc_out),
        .abc_valid_out(abc_valid_out),
        .abc_ready_in(abc_ready_in),
        .idle_out(idle_out),
        .error_out(error_out),
        .error_code_out(error_code_out)
    );

    always #5 clk_in = ~clk_in;

    // Reference model
    logic [LW-1:0] m_mem [int];
    logic [15:0]   m_stage [W];
    bit            m_have [W];
    int            m_addr;
    bit            m_err;
    logic [1:0]    m_code;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [LW-1:0] obs,
                       input logic [LW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void m_reset();
        for (int k = 0; k < W; k++) m_have[k] = 1'b0;
        m_err  = 1'b0;
        m_code = 2'b00;
        m_addr = 0;
    endfunction

    function automatic void m_raise(input logic [1:0] c);
        if (!m_err) begin
            m_err  = 1'b1;
            m_code = c;
        end
    endfunction

    function automatic void m_bump();
`ifdef DATA_CACHE_AUTOINC_EN
        m_addr = (m_addr + 1) % D;
`endif
    endfunction

    function automatic bit m_empty();
        bit e = 1'b1;
        for (int k = 0; k < W; k++) if (m_have[k]) e = 1'b0;
        return e;
    endfunction

    function automatic bit m_full();
        bit f = 1'b1;
        for (int k = 0; k < W; k++) if (!m_have[k]) f = 1'b0;
        return f;
    endfunction

    function automatic logic [LW-1:0] m_pack();
        logic [LW-1:0] v;
        for (int k = 0; k < W; k++) v[LW-1-16*k -: 16] = m_stage[k];
        return v;
    endfunction

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check_status();
        chk("error_out", {95'd0, error_out}, {95'd0, m_err});
        chk("error_code", {94'd0, error_code_out}, {94'd0, m_code});
        chk("idle_out", {95'd0, idle_out}, {95'd0, m_empty()});
    endtask

    task automatic chk_reset_vals();
        chk("rst_instr_ready", {95'd0, instr_ready_out}, 96'd1);
        chk("rst_idle", {95'd0, idle_out}, 96'd1);
        chk("rst_buf_ready", {95'd0, buffer_ready_out}, 96'd0);
        chk("rst_abc_out", abc_out, 96'd0);
        chk("rst_abc_valid", {95'd0, abc_valid_out}, 96'd0);
        chk("rst_error", {95'd0, error_out}, 96'd0);
        chk("rst_code", {94'd0, error_code_out}, 96'd0);
    endtask

    // Offer one instruction and return #1 after the edge that accepts it
    task automatic send(input logic [3:0] op, input logic [3:0] rf,
                        input logic [15:0] imm);
        int n = 0;
        instr_in       = {op, rf, imm, 8'($urandom)};
        instr_valid_in = 1'b1;
        while (instr_ready_out !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk("instr_ready", {95'd0, instr_ready_out}, 96'd1);
        step();
        instr_valid_in = 1'b0;
        instr_in       = $urandom;
    endtask

    task automatic sma(input int imm);
        send(4'b0110, 4'($urandom), 16'(imm));
        if (imm < D) m_addr = imm;
        else m_raise(2'b10);
        check_status();
    endtask

    task automatic loadi(input int r, input logic [15:0] v);
        send(4'b0111, 4'(r), v);
        if (r < W) begin
            m_stage[r] = v;
            m_have[r]  = 1'b1;
            if (m_full()) begin
                m_mem[m_addr] = m_pack();
                for (int k = 0; k < W; k++) m_have[k] = 1'b0;
                m_bump();
                chk("wr_line_busy", {95'd0, instr_ready_out}, 96'd0);
                step();
            end
        end else begin
            m_raise(2'b01);
        end
        chk("ready_after_loadi", {95'd0, instr_ready_out}, 96'd1);
        check_status();
    endtask

    task automatic loadb(input logic [LW-1:0] data, input int dly);
        send(4'b1000, 4'($urandom), 16'($urandom));
        chk("buf_ready", {95'd0, buffer_ready_out}, 96'd1);
        for (int i = 0; i < dly; i++) begin
            buffer_data_in  = {3{$urandom}};
            buffer_valid_in = 1'b0;
            abc_ready_in    = 1'($urandom);
            step();
            chk("buf_wait", {95'd0, buffer_ready_out}, 96'd1);
        end
        abc_ready_in    = 1'b0;
        buffer_data_in  = data;
        buffer_valid_in = 1'b1;
        step();
        buffer_valid_in = 1'b0;
        buffer_data_in  = {3{$urandom}};
        chk("buf_done", {95'd0, buffer_ready_out}, 96'd0);
        m_mem[m_addr] = data;
        m_bump();
        check_status();
    endtask

    task automatic writeb(input int hold);
        logic [LW-1:0] exp;
        bit            known;
        int            lat = 0;
        known = m_mem.exists(m_addr);
        exp   = known ? m_mem[m_addr] : '0;
        send(4'b1001, 4'($urandom), 16'($urandom));
        while (abc_valid_out !== 1'b1 && lat < 20) begin
            step();
            lat++;
        end
        chk("abc_latency", 96'(lat), 96'(RL + 1));
        if (known) chk("abc_data", abc_out, exp);
        for (int i = 0; i < hold; i++) begin
            step();
            chk("abc_hold_valid", {95'd0, abc_valid_out}, 96'd1);
            if (known) chk("abc_hold_data", abc_out, exp);
        end
        abc_ready_in = 1'b1;
        step();
        abc_ready_in = 1'b0;
        chk("abc_released", {95'd0, abc_valid_out}, 96'd0);
        chk("ready_after_wb", {95'd0, instr_ready_out}, 96'd1);
        m_bump();
        check_status();
    endtask

    task automatic pulse_reset();
        rst_in = 1'b1;
        #1;
        chk_reset_vals();
        step();
        rst_in = 1'b0;
        m_reset();
        step();
        chk_reset_vals();
    endtask

    initial begin
        logic [LW-1:0] line_x;
        logic [LW-1:0] line_y;
        rst_in          = 1'b1;
        instr_in        = '0;
        instr_valid_in  = 1'b0;
        buffer_data_in  = '0;
        buffer_valid_in = 1'b0;
        abc_ready_in    = 1'b0;
        m_reset();
        #2;
        chk_reset_vals();
        step();
        step();
        rst_in = 1'b0;
        step();

        // Fill a line word by word, then read it back
        sma(5);
        for (int k = 0; k < W; k++) loadi(k, 16'(16'h1111 * (k + 1)));
        sma(5);
        writeb(0);

        // Buffer line with a late handshake; stray buffer_valid in IDLE ignored
        buffer_valid_in = 1'b1;
        buffer_data_in  = {3{$urandom}};
        sma(10);
        buffer_valid_in = 1'b0;
        loadb({12{8'hA5}}, 4);
        sma(10);
        writeb(5);

        // Last-line boundary and address wrap
        line_x = {3{$urandom}};
        line_y = {3{$urandom}};
        sma(374);
        loadb(line_x, 0);
        loadb(line_y, 1);
        sma(374);
        writeb(0);
        sma(0);
        writeb(1);

        // First error is kept; bad instructions leave addr and mask alone
        sma(10);
        loadi(7, 16'hDEAD);
        sma(400);
        writeb(0);

        // Reset while a read is in flight
        sma(5);
        send(4'b1001, 4'd0, 16'd0);
        pulse_reset();

        // Reset with a partly filled staging line
        sma(20);
        for (int k = 0; k < 3; k++) loadi(k, 16'($urandom));
        pulse_reset();
        sma(20);
        for (int k = 3; k < W; k++) loadi(k, 16'($urandom));
        for (int k = 0; k < 3; k++) loadi(k, 16'($urandom));
        sma(20);
        writeb(1);
        sma(5);
        writeb(0);

        // Random instruction stream
        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(0, 6))
                0: sma(($urandom_range(0, 9) == 0) ? D + int'($urandom_range(0, 99))
                                                   : int'($urandom_range(0, D - 1)));
                1, 2: loadi(int'($urandom_range(0, 6)), 16'($urandom));
                3: loadb({3{$urandom}}, int'($urandom_range(0, 3)));
                4: writeb(int'($urandom_range(0, 3)));
                5: begin
                    sma(int'($urandom_range(0, 3)));
                    writeb(0);
                end
                default: begin
                    send(4'($urandom_range(10, 15)), 4'($urandom), 16'($urandom));
                    check_status();
                end
            endcase
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
